// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: programmable period counter, registered div_clk/tick,
// start/stop/burst sequencing, boundary-aligned divisor updates. Burst option: CLK_DIV_CTRL_BURST_EN.
module clk_div_ctrl #(
  parameter int CNT_W       = 16,
  parameter int BURST_W     = 8,
  parameter int DEFAULT_DIV = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  output logic               div_clk,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  // state      | meaning
  // S_IDLE     | counter parked, divisor writes go straight to the active register
  // S_RUN      | counting periods, divisor writes held pending until the wrap
  // S_STOPPING | stop seen, finishing the current period before returning idle
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOPPING
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [CNT_W-1:0]   div_act, div_nx;
  logic [CNT_W-1:0]   pend_div, pend_div_nx;
  logic               pend_vld, pend_vld_nx;
  logic [CNT_W-1:0]   cfg_clamped;
  logic               cfg_hs;
  logic               wrap;
  logic               run_go;
  logic               burst_end;
  logic               active_nx;

  assign cfg_clamped = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
  assign cfg_hs      = cfg_valid & cfg_ready;
  assign wrap        = (cnt == div_act);
  assign run_go      = (state == S_IDLE) && start && !stop;

`ifdef CLK_DIV_CTRL_BURST_EN
  logic [BURST_W-1:0] burst_lat;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_inc;

  assign burst_inc = burst_cnt + BURST_W'(1);
  assign burst_end = (burst_lat != '0) && (burst_inc == burst_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_lat <= '0;
      burst_cnt <= '0;
    end else if (run_go) begin
      burst_lat <= burst_len;
      burst_cnt <= '0;
    end else if ((state != S_IDLE) && wrap) begin
      burst_cnt <= burst_inc;
    end
  end
`else
  logic burst_len_unused;

  assign burst_len_unused = ^burst_len;
  assign burst_end        = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    div_nx      = div_act;
    pend_div_nx = pend_div;
    pend_vld_nx = pend_vld;
    case (state)
      S_IDLE: begin
        if (cfg_hs) div_nx = cfg_clamped;
        if (run_go) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end
      end
      S_RUN, S_STOPPING: begin
        if (wrap) begin
          cnt_nx = '0;
          // a write landing on the wrap itself takes effect for the next period
          if (pend_vld) begin
            div_nx      = pend_div;
            pend_vld_nx = 1'b0;
          end else if (cfg_hs) begin
            div_nx = cfg_clamped;
          end
          if ((state == S_STOPPING) || stop || burst_end) state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
          if (cfg_hs) begin
            pend_vld_nx = 1'b1;
            pend_div_nx = cfg_clamped;
          end
          if ((state == S_RUN) && stop) state_nx = S_STOPPING;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (state_nx == S_IDLE) cnt_nx = '0;
    active_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_act  <= CNT_W'(DEFAULT_DIV);
      pend_div <= '0;
      pend_vld <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      div_act  <= div_nx;
      pend_div <= pend_div_nx;
      pend_vld <= pend_vld_nx;
    end
  end

  // outputs are registered from next-state values so they align with cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_clk   <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      div_clk   <= active_nx && (cnt_nx <= (div_nx >> 1));
      tick      <= active_nx && (cnt_nx == '0);
      busy      <= active_nx;
      done      <= (state != S_IDLE) && !active_nx;
      cfg_ready <= !active_nx || !pend_vld_nx;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: stimulus queues expected tick/fall/done cycles,
// a negedge monitor pops and compares them as the DUT produces events.
module tb_clk_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] cfg_div;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        start;
  logic        stop;
  logic [7:0]  burst_len;
  logic        div_clk;
  logic        tick;
  logic        busy;
  logic        done;

  clk_div_ctrl #(.CNT_W(16), .BURST_W(8), .DEFAULT_DIV(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .div_clk   (div_clk),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_q[$];
  int fall_q[$];
  int done_q[$];
  int mon_req;
  logic prev_div = 1'b0;
  int s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event_at_cycle_%0d required=none", name, cyc);
  endtask

  always @(negedge clk) begin
    if (prev_div && !div_clk) begin
      if (fall_q.size() == 0) unexpected("div_clk_fall");
      else begin
        mon_req = fall_q.pop_front();
        chk("div_clk_fall_cycle", cyc, mon_req);
      end
    end
    if (tick) begin
      if (tick_q.size() == 0) unexpected("tick");
      else begin
        mon_req = tick_q.pop_front();
        chk("tick_cycle", cyc, mon_req);
      end
    end
    if (done) begin
      if (done_q.size() == 0) unexpected("done");
      else begin
        mon_req = done_q.pop_front();
        chk("done_cycle", cyc, mon_req);
      end
    end
    prev_div = div_clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic cfg_load(input int d);
    chk("cfg_ready_idle", int'(cfg_ready), 1);
    cfg_div   = 16'(d);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cfg_div   = '0;
    cfg_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    burst_len = '0;
    step();
    step();
    chk("rst_div_clk", int'(div_clk), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    rst_n = 1'b1;
    step();
    step();

    // default divisor 15: period 16, high 8
    s = cyc;
    tick_q.push_back(s + 1); tick_q.push_back(s + 17); tick_q.push_back(s + 33);
    fall_q.push_back(s + 9); fall_q.push_back(s + 25); fall_q.push_back(s + 41);
    done_q.push_back(s + 49);
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    wait_to(s + 36);
    pulse_stop();
    wait_to(s + 48);
    chk("busy_stopping", int'(busy), 1);
    wait_to(s + 50);
    chk("busy_after_stop", int'(busy), 0);

    // divisor change 15 -> 3 mid-period
    s = cyc;
    tick_q.push_back(s + 1); tick_q.push_back(s + 17);
    tick_q.push_back(s + 21); tick_q.push_back(s + 25);
    fall_q.push_back(s + 9); fall_q.push_back(s + 19);
    fall_q.push_back(s + 23); fall_q.push_back(s + 27);
    done_q.push_back(s + 29);
    pulse_start();
    wait_to(s + 6);
    chk("cfg_ready_run", int'(cfg_ready), 1);
    cfg_div   = 16'd3;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("cfg_ready_pending", int'(cfg_ready), 0);
    wait_to(s + 16);
    chk("cfg_ready_wrap", int'(cfg_ready), 0);
    step();
    chk("cfg_ready_applied", int'(cfg_ready), 1);
    wait_to(s + 26);
    pulse_stop();
    wait_to(s + 30);

    // D=7, stop at cnt=2
    cfg_load(7);
    s = cyc;
    tick_q.push_back(s + 1);
    fall_q.push_back(s + 5);
    done_q.push_back(s + 9);
    pulse_start();
    wait_to(s + 3);
    pulse_stop();
    wait_to(s + 10);

    // start and stop together in IDLE: nothing happens
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    repeat (4) step();
    chk("start_stop_busy", int'(busy), 0);
    chk("start_stop_div_clk", int'(div_clk), 0);

    // D=0 clamps to 1: div_clk alternates 1,0
    cfg_load(0);
    s = cyc;
    tick_q.push_back(s + 1); tick_q.push_back(s + 3); tick_q.push_back(s + 5);
    fall_q.push_back(s + 2); fall_q.push_back(s + 4); fall_q.push_back(s + 6);
    done_q.push_back(s + 7);
    pulse_start();
    wait_to(s + 5);
    pulse_stop();
    wait_to(s + 8);

    // burst_len=3 with D=4
    cfg_load(4);
    burst_len = 8'd3;
    s = cyc;
    tick_q.push_back(s + 1); tick_q.push_back(s + 6); tick_q.push_back(s + 11);
    fall_q.push_back(s + 4); fall_q.push_back(s + 9); fall_q.push_back(s + 14);
`ifdef CLK_DIV_CTRL_BURST_EN
    done_q.push_back(s + 16);
    pulse_start();
    burst_len = '0;
    wait_to(s + 15);
    chk("burst_busy_last", int'(busy), 1);
    step();
    chk("burst_busy_end", int'(busy), 0);
    step();
`else
    tick_q.push_back(s + 16);
    fall_q.push_back(s + 19);
    done_q.push_back(s + 21);
    pulse_start();
    burst_len = '0;
    wait_to(s + 16);
    chk("noburst_busy", int'(busy), 1);
    step();
    pulse_stop();
    wait_to(s + 22);
    chk("noburst_busy_end", int'(busy), 0);
`endif

    // async reset mid-high phase with D=9
    cfg_load(9);
    s = cyc;
    tick_q.push_back(s + 1);
    fall_q.push_back(s + 3);
    pulse_start();
    wait_to(s + 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_div_clk", int'(div_clk), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_cfg_ready", int'(cfg_ready), 1);
    step();
    step();
    rst_n = 1'b1;
    step();
    s = cyc;
    tick_q.push_back(s + 1); tick_q.push_back(s + 17);
    fall_q.push_back(s + 9); fall_q.push_back(s + 25);
    done_q.push_back(s + 33);
    pulse_start();
    wait_to(s + 20);
    pulse_stop();
    wait_to(s + 36);

    chk("tick_q_left", tick_q.size(), 0);
    chk("fall_q_left", fall_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the fabric's divided-clock generator. It owns a programmable period counter and produces a registered divided-clock level (`div_clk`) plus a one-cycle `tick` on each rising edge of that level. It sequences start, stop and finite bursts, and accepts divisor changes through a valid/ready handshake, applying them only at period boundaries so `div_clk` never produces a runt pulse. It sits between the control/register logic and every consumer of the slow clock enable.

## Interface
- `CNT_W`, 16: width of divisor and period counter.
- `BURST_W`, 8: width of burst length.
- `DEFAULT_DIV`, 15: divisor loaded at reset; period = 16 cycles.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cfg_div`  in  CNT_W  new divisor D; period = D+1 cycles; D=0 clamped to 1.
- `cfg_valid`  in  1  `cfg_div` offered.
- `cfg_ready`  out  1  divisor can be accepted.
- `start`  in  1  level-sampled start request.
- `stop`  in  1  level-sampled stop request.
- `burst_len`  in  BURST_W  periods to run, sampled at start; 0 = continuous.
- `div_clk`  out  1  divided clock level, registered.
- `tick`  out  1  one-cycle pulse coincident with each rising edge of `div_clk`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE.

## Operation
- **Reset values:**
  - state=IDLE, cnt=0.
  - active divisor=`DEFAULT_DIV`, no pending divisor, burst counter=0.
  - Outputs: `div_clk`=0, `tick`=0, `busy`=0, `done`=0, `cfg_ready`=1.
- **States:** IDLE, RUN, STOPPING.
- **IDLE:**
  - `cfg_ready`=1. A handshake writes the active divisor directly.
  - `start`=1 and `stop`=0 → RUN. `cnt` is set to 0 and `burst_len` is latched.
  - `start` and `stop` both high → stay in IDLE; `stop` wins.
- **RUN:**
  - `cnt` counts 0..D, then wraps to 0.
  - `div_clk`=1 while `cnt` ≤ D>>1, else 0. High time is (D>>1)+1 cycles.
  - `tick`=1 whenever `cnt`=0.
- **Divisor change while running:**
  - A handshake (`cfg_valid`&`cfg_ready`) stores a pending divisor and drops `cfg_ready`.
  - The pending value becomes active on the wrap cycle (`cnt`=D), then `cfg_ready` returns to 1.
  - A handshake on the wrap cycle itself applies to the very next period.
- **Stop:** `stop` in RUN → STOPPING. The current period completes. At wrap → IDLE with `div_clk`=0 and `done`=1.
- **Burst end:** the burst counter increments at each wrap. When it equals a nonzero latched `burst_len`, the FSM goes to IDLE and pulses `done`. This happens without entering STOPPING.
- **STOPPING:**
  - `start` is ignored.
  - `cfg_ready` follows the RUN rules, so a pending divisor is still applied at the wrap.
- **Reset mid-run:** asynchronous return to reset values. `div_clk` drops immediately and no `done` pulse is produced.
- **Arithmetic:** the counter and divisor are CNT_W wide with no overflow, since `cnt` ≤ D always. `burst_len`=2^BURST_W−1 is the maximum finite burst.

## Timing
- All outputs are registered.
- Latency:
  - `start` sampled at edge N → `busy`=1, `div_clk`=1, `tick`=1 from edge N+1.
  - Last wrap cycle at edge M → IDLE, `div_clk`=0, `busy`=0, `done`=1 from edge M+1. `done` is high for exactly one cycle.
- `tick` period equals D+1 cycles exactly, including across a divisor change. The old period finishes in full and the new period begins at `cnt`=0.
- `cfg_ready` is low from the cycle after an accepted RUN/STOPPING handshake until the cycle after the wrap that applies the value.
- Minimum period is 2 cycles (D=1): `div_clk` alternates 1,0.

## Configuration
- **Macro:** `CLK_DIV_CTRL_BURST_EN`.
- **Defined:** burst counting as above. `done` also fires on burst completion.
- **Undefined:**
  - `burst_len` is ignored and the burst counter is not built.
  - Every run is continuous; only `stop` ends it and produces `done`.

## Test plan
- Reset defaults: release `rst_n`, pulse `start` → `tick` every 16 cycles, `div_clk` high 8 cycles / low 8 cycles.
- On-the-fly divisor change: with D=15 running, offer `cfg_div`=3 mid-period.
  - `cfg_ready` drops.
  - Current 16-cycle period completes.
  - Then `tick` every 4 cycles, `div_clk` high 2 / low 2.
  - `cfg_ready` returns high.
- Burst (macro defined): D=4, `burst_len`=3, `start` → exactly 3 ticks 5 cycles apart. `done` fires one cycle after the 15th running cycle; `busy` falls with it.
- Stop and clamp:
  - `stop` at `cnt`=2 of a D=7 period → period finishes at `cnt`=7, then IDLE with `done`=1.
  - `start` and `stop` high together in IDLE → no activity.
  - `cfg_div`=0 → period of 2 cycles.
- Async reset: assert `rst_n` low mid-high phase → `div_clk`=0 and `busy`=0 immediately, no `done`. After release, the divisor is `DEFAULT_DIV` again.
